mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 34 +++
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: widths, FSM states, access-width codes
// and the byte counts they map to.
package mem_arbiter_pkg;

    localparam int unsigned AddrW  = 32;
    localparam int unsigned InstrW = 32;

    typedef enum logic [2:0] {
        StIdle,
        StIread,
        StDread,
        StDwrite,
        StDone
    } state_t;

    localparam logic [1:0] WidthByte = 2'd0;
    localparam logic [1:0] WidthHalf = 2'd1;
    localparam logic [1:0] WidthWord = 2'd2;

    localparam logic [2:0] NBytesByte = 3'd1;
    localparam logic [2:0] NBytesHalf = 3'd2;
    localparam logic [2:0] NBytesWord = 3'd4;

    // Number of RAM bytes touched by an access; the unused code 3 is treated as a word.
    function automatic logic [2:0] width_nbytes(input logic [1:0] width);
        unique case (width)
            WidthByte: width_nbytes = NBytesByte;
            WidthHalf: width_nbytes = NBytesHalf;
            WidthWord: width_nbytes = NBytesWord;
            default:   width_nbytes = NBytesWord;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter between instruction fetch and data load/store onto a byte-wide RAM.
// Multi-byte accesses are serialised little-endian, one byte per cycle.
// Option: define MEM_ARBITER_ROUND_ROBIN_EN to alternate grants when both sides
// are pending; otherwise data requests always beat fetches.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              instruction_read_flag,
    input  logic [AddrW-1:0]  instruction_read_address,
    output logic              instruction_flag,
    output logic [AddrW-1:0]  instruction_read_address_o,
    output logic [InstrW-1:0] instruction,
    input  logic              data_read_flag,
    input  logic              data_write_flag,
    input  logic [AddrW-1:0]  data_address,
    input  logic [1:0]        data_width,
    input  logic [31:0]       data_write,
    output logic              data_done,
    output logic [31:0]       data_read,
    output logic [AddrW-1:0]  mem_a,
    output logic [7:0]        mem_dout,
    output logic              mem_wr,
    input  logic [7:0]        mem_din
);

    state_t           state_q;
    logic [AddrW-1:0] base_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic [2:0]       cnt_q;
    logic [2:0]       nbytes_q;
    logic             is_data_q;

    logic        data_req;
    logic        grant_data;
    logic [2:0]  cnt_inc;
    logic [1:0]  rd_idx;
    logic [31:0] rdata_next;
    logic [7:0]  wbyte_next;

    assign data_req = data_read_flag | data_write_flag;
    assign cnt_inc  = cnt_q + 3'd1;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // Set when the most recent grant went to the data side.
    logic last_data_q;
    assign grant_data = data_req & (~instruction_read_flag | ~last_data_q);
`else
    assign grant_data = data_req;
`endif

    // Merge the byte returned for address base+c-1 into the assembled read word.
    always_comb begin
        rd_idx     = 2'(cnt_q - 3'd1);
        rdata_next = rdata_q;
        if (cnt_q != 3'd0) begin
            rdata_next = rdata_q | (32'(mem_din) << {rd_idx, 3'b000});
        end
        wbyte_next = 8'(wdata_q >> {cnt_inc[1:0], 3'b000});
    end

    // Arbitration, byte sequencing and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q                    <= StIdle;
            base_q                     <= '0;
            wdata_q                    <= '0;
            rdata_q                    <= '0;
            cnt_q                      <= '0;
            nbytes_q                   <= '0;
            is_data_q                  <= 1'b0;
            instruction_flag           <= 1'b0;
            instruction_read_address_o <= '0;
            instruction                <= '0;
            data_done                  <= 1'b0;
            data_read                  <= '0;
            mem_a                      <= '0;
            mem_dout                   <= '0;
            mem_wr                     <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_data_q                <= 1'b0;
`endif
        end else begin
            // Completion pulses and RAM strobes are single-cycle unless re-driven below.
            instruction_flag           <= 1'b0;
            instruction_read_address_o <= '0;
            instruction                <= '0;
            data_done                  <= 1'b0;
            data_read                  <= '0;
            mem_a                      <= '0;
            mem_dout                   <= '0;
            mem_wr                     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q   <= '0;
                    rdata_q <= '0;
                    if (grant_data) begin
                        base_q    <= data_address;
                        wdata_q   <= data_write;
                        nbytes_q  <= width_nbytes(data_width);
                        is_data_q <= 1'b1;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                        last_data_q <= 1'b1;
`endif
                        if (data_read_flag) begin
                            state_q <= StDread;
                        end else begin
                            // First store byte goes out together with acceptance.
                            state_q  <= StDwrite;
                            mem_a    <= data_address;
                            mem_dout <= data_write[7:0];
                            mem_wr   <= 1'b1;
                        end
                    end else if (instruction_read_flag) begin
                        base_q    <= instruction_read_address;
                        nbytes_q  <= NBytesWord;
                        is_data_q <= 1'b0;
                        state_q   <= StIread;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                        last_data_q <= 1'b0;
`endif
                    end
                end
                StIread, StDread: begin
                    if (cnt_q == nbytes_q) begin
                        state_q <= StDone;
                        if (is_data_q) begin
                            data_done <= 1'b1;
                            data_read <= rdata_next;
                        end else begin
                            instruction_flag           <= 1'b1;
                            instruction                <= rdata_next;
                            instruction_read_address_o <= base_q;
                        end
                    end else begin
                        mem_a   <= base_q + AddrW'(cnt_q);
                        rdata_q <= rdata_next;
                        cnt_q   <= cnt_inc;
                    end
                end
                StDwrite: begin
                    if (cnt_inc == nbytes_q) begin
                        state_q   <= StDone;
                        data_done <= 1'b1;
                    end else begin
                        mem_a    <= base_q + AddrW'(cnt_inc);
                        mem_dout <= wbyte_next;
                        mem_wr   <= 1'b1;
                    end
                    cnt_q <= cnt_inc;
                end
                StDone: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// fetch/load/store traffic, compared against a transaction-level memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instruction_read_flag = 1'b0;
    logic [31:0] instruction_read_address = '0;
    logic        instruction_flag;
    logic [31:0] instruction_read_address_o;
    logic [31:0] instruction;
    logic        data_read_flag = 1'b0;
    logic        data_write_flag = 1'b0;
    logic [31:0] data_address = '0;
    logic [1:0]  data_width = '0;
    logic [31:0] data_write = '0;
    logic        data_done;
    logic [31:0] data_read;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;

    mem_arbiter dut (
        .clk                        (clk),
        .rst                        (rst),
        .instruction_read_flag      (instruction_read_flag),
        .instruction_read_address   (instruction_read_address),
        .instruction_flag           (instruction_flag),
        .instruction_read_address_o (instruction_read_address_o),
        .instruction                (instruction),
        .data_read_flag             (data_read_flag),
        .data_write_flag            (data_write_flag),
        .data_address               (data_address),
        .data_width                 (data_width),
        .data_write                 (data_write),
        .data_done                  (data_done),
        .data_read                  (data_read),
        .mem_a                      (mem_a),
        .mem_dout                   (mem_dout),
        .mem_wr                     (mem_wr),
        .mem_din                    (mem_din)
    );

    always #5 clk = ~clk;

    // 256-byte RAM aliased over the address space; read data follows mem_a.
    logic [7:0] ram [256];
    logic [7:0] ref_mem [256];
    assign mem_din = ram[mem_a[7:0]];
    always @(posedge clk) if (mem_wr) ram[mem_a[7:0]] = mem_dout;

    int n_iflag = 0;
    int n_ddone = 0;
    always @(negedge clk) begin
        if (instruction_flag) n_iflag++;
        if (data_done) n_ddone++;
    end

    int checks = 0;
    int failures = 0;
    bit m_last_data = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nb(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit data_first(input bit f, input bit d);
        if (!d) return 1'b0;
        if (!f) return 1'b1;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        return !m_last_data;
`else
        return 1'b1;
`endif
    endfunction

    // kind: 0 fetch, 1 load, 2 store. Starts with the request already pending
    // and the DUT idle; ends one edge after the completion pulse.
    task automatic serve(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                         input int n);
        logic [31:0] exp;
        logic [7:0]  idx;
        int          k;
        int          lat;
        bit          seen;
        exp = '0;
        for (int i = 0; i < n; i++) begin
            idx = 8'(addr + 32'(i));
            exp = exp | (32'(ref_mem[idx]) << (8 * i));
        end
        lat  = (kind == 2) ? n : n + 1;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < lat + 8) begin
            @(posedge clk);
            #1;
            k++;
            if (kind == 2 && k <= n) begin
                check_eq("st_addr", mem_a, addr + 32'(k - 1));
                check_eq("st_wr", 32'(mem_wr), 32'd1);
                check_eq("st_byte", 32'(mem_dout), 32'(8'(wd >> (8 * (k - 1)))));
            end
            if (kind != 2 && k >= 2 && k <= n + 1) begin
                check_eq("rd_addr", mem_a, addr + 32'(k - 2));
                check_eq("rd_wr", 32'(mem_wr), 32'd0);
            end
            seen = (kind == 0) ? instruction_flag : data_done;
        end
        check_eq("latency", 32'(k), 32'(lat + 1));
        if (seen) begin
            if (kind == 0) begin
                check_eq("instr", instruction, exp);
                check_eq("echo", instruction_read_address_o, addr);
                check_eq("no_ddone", 32'(data_done), 32'd0);
            end else begin
                if (kind == 1) check_eq("load", data_read, exp);
                check_eq("no_iflag", 32'(instruction_flag), 32'd0);
            end
            check_eq("idle_wr", 32'(mem_wr), 32'd0);
        end
        if (kind == 2) begin
            for (int i = 0; i < n; i++) ref_mem[8'(addr + 32'(i))] = 8'(wd >> (8 * i));
        end
        m_last_data = (kind != 0);
        @(negedge clk);
        if (kind == 0) instruction_read_flag = 1'b0;
        else begin
            data_read_flag  = 1'b0;
            data_write_flag = 1'b0;
        end
        @(posedge clk);
        #1;
        check_eq("pulse_len", 32'(instruction_flag | data_done), 32'd0);
    endtask

    task automatic do_txn(input bit f, input bit dr, input bit dw, input logic [31:0] faddr,
                          input logic [31:0] daddr, input logic [31:0] wd, input logic [1:0] w);
        int  i0;
        int  d0;
        int  dkind;
        bit  d;
        @(negedge clk);
        instruction_read_flag    = f;
        instruction_read_address = faddr;
        data_read_flag           = dr;
        data_write_flag          = dw;
        data_address             = daddr;
        data_width               = w;
        data_write               = wd;
        i0    = n_iflag;
        d0    = n_ddone;
        d     = dr | dw;
        dkind = dr ? 1 : 2;
        if (data_first(f, d)) begin
            serve(dkind, daddr, wd, nb(w));
            if (f) serve(0, faddr, 32'd0, 4);
        end else begin
            if (f) serve(0, faddr, 32'd0, 4);
            if (d) serve(dkind, daddr, wd, nb(w));
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("iflag_cnt", 32'(n_iflag - i0), 32'(f));
        check_eq("ddone_cnt", 32'(n_ddone - d0), 32'(d));
    endtask

    initial begin
        int          d0;
        int          i0;
        int          k;
        logic [31:0] exp;
        logic [31:0] fa;
        logic [31:0] da;
        logic [1:0]  w;
        int          sel;

        for (int i = 0; i < 256; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        ram[8'h00] = 8'h13; ram[8'h01] = 8'h05; ram[8'h02] = 8'h00; ram[8'h03] = 8'h00;
        ram[8'h30] = 8'h80;
        for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];

        #1;
        check_eq("rst_iflag", 32'(instruction_flag), 32'd0);
        check_eq("rst_ddone", 32'(data_done), 32'd0);
        check_eq("rst_wr", 32'(mem_wr), 32'd0);
        check_eq("rst_a", mem_a, 32'd0);
        check_eq("rst_instr", instruction, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed scenarios.
        do_txn(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 2'd2);
        check_eq("fetch_word", instruction, 32'h0);
        do_txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h20, 32'hDEADBEEF, 2'd2);
        check_eq("store_ram", {ram[8'h23], ram[8'h22], ram[8'h21], ram[8'h20]}, 32'hDEADBEEF);
        do_txn(1'b1, 1'b1, 1'b0, 32'h100, 32'h30, 32'h0, 2'd0);
        do_txn(1'b1, 1'b1, 1'b0, 32'h104, 32'h31, 32'h0, 2'd1);
        do_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFFFFFE, 32'h0, 2'd2);
        do_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h44, 32'h12345678, 2'd2);

        // Reset while the second store byte is on the bus.
        @(negedge clk);
        data_write_flag = 1'b1;
        data_address    = 32'h40;
        data_width      = 2'd2;
        data_write      = 32'h11223344;
        d0 = n_ddone;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rstmid_wr", 32'(mem_wr), 32'd0);
        check_eq("rstmid_a", mem_a, 32'd0);
        check_eq("rstmid_dout", 32'(mem_dout), 32'd0);
        check_eq("rstmid_done", 32'(data_done), 32'd0);
        ref_mem[8'h40] = 8'h44;
        m_last_data    = 1'b0;
        data_write_flag = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_eq("rstmid_nodone", 32'(n_ddone - d0), 32'd0);
        do_txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 2'd2);

        // Fetch request withdrawn two cycles in still completes exactly once.
        @(negedge clk);
        instruction_read_flag    = 1'b1;
        instruction_read_address = 32'h80;
        i0  = n_iflag;
        exp = {ref_mem[8'h83], ref_mem[8'h82], ref_mem[8'h81], ref_mem[8'h80]};
        @(negedge clk);
        @(negedge clk);
        instruction_read_flag = 1'b0;
        k = 2;
        while (!instruction_flag && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("drop_lat", 32'(k), 32'd6);
        check_eq("drop_echo", instruction_read_address_o, 32'h80);
        check_eq("drop_instr", instruction, exp);
        m_last_data = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("drop_once", 32'(n_iflag - i0), 32'd1);

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 3);
            fa  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                               : $urandom;
            da  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                               : $urandom;
            w   = 2'($urandom_range(0, 2));
            case (sel)
                0: do_txn(1'b1, 1'b0, 1'b0, fa, da, $urandom, w);
                1: do_txn(1'b0, 1'b1, 1'b0, fa, da, $urandom, w);
                2: do_txn(1'b0, 1'b0, 1'b1, fa, da, $urandom, w);
                default: begin
                    if ($urandom_range(0, 1) == 1) do_txn(1'b1, 1'b1, 1'b0, fa, da, $urandom, w);
                    else do_txn(1'b1, 1'b0, 1'b1, fa, da, $urandom, w);
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
